bid_ctrl_multi: RTL and testbench

Parametrised, fully registered successor of the three-player bid controller. It supports NUM_PLAYERS bidders and configurable balance and bid widths. It adds per-player insufficient-funds checking, a real bad-key lockout counter, and deterministic tie-breaking. The block sits between the bidder front-ends and the host control port.

---
 rtl/bid_ctrl_multi.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_bid_ctrl_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bid_ctrl_multi.sv
// Parametrised multi-player bid controller: host-locked configuration, key lockout,
// per-player funds checking and lowest-index tie-breaking, with all outputs registered.
module bid_ctrl_multi #(
  parameter int NUM_PLAYERS = 4,
  parameter int BAL_W       = 32,
  parameter int BID_W       = 16,
  parameter int TIMER_W     = 4,
  parameter int SEL_W       = $clog2(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PLAYERS*BID_W-1:0] bid_amt,
  input  logic [NUM_PLAYERS-1:0]       bid,
  input  logic [NUM_PLAYERS-1:0]       retract,
  input  logic [BAL_W-1:0]             C_data,
  input  logic [3:0]                   C_op,
  input  logic [SEL_W-1:0]             C_sel,
  input  logic                         C_start,
  output logic [NUM_PLAYERS-1:0]       ack,
  output logic [2*NUM_PLAYERS-1:0]     p_err,
  output logic [NUM_PLAYERS*BAL_W-1:0] balance,
  output logic [NUM_PLAYERS-1:0]       win,
  output logic                         ready,
  output logic [2:0]                   err,
  output logic                         roundOver,
  output logic [BAL_W-1:0]             maxBid
);

  localparam int EXT_W = BAL_W + 1;
  localparam logic [SEL_W:0] NP_SEL = (SEL_W + 1)'(NUM_PLAYERS);

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOADP  = 4'd3;
  localparam logic [3:0] OP_MASK   = 4'd4;
  localparam logic [3:0] OP_TIMER  = 4'd5;
  localparam logic [3:0] OP_CHARGE = 4'd6;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_KEY      = 3'd1;
  localparam logic [2:0] ERR_UNLOCKED = 3'd2;
  localparam logic [2:0] ERR_START    = 3'd3;
  localparam logic [2:0] ERR_OP       = 3'd4;
  localparam logic [2:0] ERR_SEL      = 3'd5;

  localparam logic [1:0] PE_IDLE  = 2'b01;
  localparam logic [1:0] PE_FUNDS = 2'b10;
  localparam logic [1:0] PE_BLOCK = 2'b11;

  typedef enum logic [2:0] {
    ST_UNLOCKED = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_LOCKOUT  = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_OVER     = 3'd4
  } state_t;

  state_t                 state_r;
  logic [BAL_W-1:0]       value_r [NUM_PLAYERS];
  logic [BAL_W-1:0]       tent_r  [NUM_PLAYERS];
  logic [BAL_W-1:0]       tot_r   [NUM_PLAYERS];
  logic [BAL_W-1:0]       chg_r   [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] mask_r;
  logic [TIMER_W-1:0]     timer_r;
  logic [TIMER_W-1:0]     cnt_r;
  logic [BAL_W-1:0]       key_r;
  logic [BAL_W-1:0]       cost_r;

  logic [BAL_W-1:0]       amt_s [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] bid_ok_s;
  logic [NUM_PLAYERS-1:0] ret_ok_s;
  logic [NUM_PLAYERS-1:0] win_oh_s;
  logic [BAL_W-1:0]       best_s;
  logic                   take_s;
  logic [TIMER_W-1:0]     lock_cnt_s;
  logic                   key_ok_s;
  logic                   go_round_s;

  // Funds checks are widened by one bit so amount+charge can never wrap.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      amt_s[i]    = BAL_W'(bid_amt[i*BID_W +: BID_W]);
      bid_ok_s[i] = (EXT_W'(amt_s[i]) + EXT_W'(cost_r)) <= EXT_W'(tent_r[i]);
      ret_ok_s[i] = (amt_s[i] <= tot_r[i]) &&
                    (EXT_W'(cost_r) <= (EXT_W'(tent_r[i]) + EXT_W'(amt_s[i])));
    end
  end

  // Winner search: strict compare keeps the lowest index on ties; zero total means no winner.
  always_comb begin
    best_s   = '0;
    win_oh_s = '0;
    take_s   = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      take_s   = tot_r[i] > best_s;
      best_s   = take_s ? tot_r[i] : best_s;
      win_oh_s = take_s ? (NUM_PLAYERS'(1) << i) : win_oh_s;
    end
  end

  // Host control decode shared by several states.
  always_comb begin
    key_ok_s   = (C_data == key_r);
    go_round_s = C_start && ((state_r == ST_LOCKED) || (state_r == ST_OVER));
    if (timer_r == '0) begin
      lock_cnt_s = TIMER_W'(1);
    end else begin
      lock_cnt_s = timer_r;
    end
  end

  // Committed balances are driven straight from the value registers.
  always_comb begin
    balance = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      balance[i*BAL_W +: BAL_W] = value_r[i];
    end
  end

  // Control FSM, per-player round bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_UNLOCKED;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        value_r[i] <= '0;
        tent_r[i]  <= '0;
        tot_r[i]   <= '0;
        chg_r[i]   <= '0;
      end
      mask_r    <= '1;
      timer_r   <= '1;
      cnt_r     <= '0;
      key_r     <= '0;
      cost_r    <= BAL_W'(1);
      ack       <= '0;
      p_err     <= '0;
      win       <= '0;
      err       <= ERR_OK;
      roundOver <= 1'b0;
      maxBid    <= '0;
      ready     <= 1'b0;
    end else begin
      ack       <= '0;
      p_err     <= '0;
      err       <= ERR_OK;
      roundOver <= 1'b0;
      ready     <= 1'b1;
      if (go_round_s) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          tent_r[i] <= value_r[i];
          tot_r[i]  <= '0;
          chg_r[i]  <= '0;
        end
        win     <= '0;
        maxBid  <= '0;
        state_r <= ST_ACTIVE;
      end
      case (state_r)
        ST_UNLOCKED: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bid[i] || retract[i]) p_err[2*i +: 2] <= PE_IDLE;
          end
          if (C_start) begin
            err <= ERR_START;
          end else begin
            case (C_op)
              OP_NOP:    begin end
              OP_UNLOCK: err <= ERR_UNLOCKED;
              OP_LOCK: begin
                key_r   <= C_data;
                state_r <= ST_LOCKED;
              end
              OP_LOADP: begin
                if ({1'b0, C_sel} >= NP_SEL) err <= ERR_SEL;
                else value_r[C_sel] <= C_data;
              end
              OP_MASK:   mask_r  <= C_data[NUM_PLAYERS-1:0];
              OP_TIMER:  timer_r <= C_data[TIMER_W-1:0];
              OP_CHARGE: cost_r  <= C_data;
              default:   err <= ERR_OP;
            endcase
          end
        end
        ST_LOCKED: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bid[i] || retract[i]) p_err[2*i +: 2] <= PE_IDLE;
          end
          if (!C_start) begin
            case (C_op)
              OP_NOP: begin end
              OP_UNLOCK: begin
                if (key_ok_s) begin
                  state_r <= ST_UNLOCKED;
                end else begin
                  err     <= ERR_KEY;
                  cnt_r   <= lock_cnt_s;
                  ready   <= 1'b0;
                  state_r <= ST_LOCKOUT;
                end
              end
              default: err <= ERR_OP;
            endcase
          end
        end
        ST_LOCKOUT: begin
          if (cnt_r == TIMER_W'(1)) begin
            state_r <= ST_LOCKED;
          end else begin
            cnt_r <= cnt_r - TIMER_W'(1);
            ready <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (C_start) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (bid[i] || retract[i]) begin
                if (!mask_r[i]) begin
                  p_err[2*i +: 2] <= PE_BLOCK;
                end else if (bid[i] && retract[i]) begin
                  p_err[2*i +: 2] <= PE_BLOCK;
                  err             <= ERR_OP;
                end else if (bid[i]) begin
                  if (bid_ok_s[i]) begin
                    ack[i]    <= 1'b1;
                    tent_r[i] <= tent_r[i] - amt_s[i] - cost_r;
                    tot_r[i]  <= tot_r[i] + amt_s[i];
                    chg_r[i]  <= chg_r[i] + cost_r;
                  end else begin
                    p_err[2*i +: 2] <= PE_FUNDS;
                  end
                end else begin
                  if (ret_ok_s[i]) begin
                    tent_r[i] <= tent_r[i] + amt_s[i] - cost_r;
                    tot_r[i]  <= tot_r[i] - amt_s[i];
                    chg_r[i]  <= chg_r[i] + cost_r;
                  end else begin
                    p_err[2*i +: 2] <= PE_FUNDS;
                  end
                end
              end
            end
          end else begin
            // Winner pays its bids plus charges; everyone else pays only charges.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              value_r[i] <= win_oh_s[i] ? tent_r[i] : (value_r[i] - chg_r[i]);
            end
            win       <= win_oh_s;
            maxBid    <= best_s;
            roundOver <= 1'b1;
            state_r   <= ST_OVER;
          end
        end
        ST_OVER: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bid[i] || retract[i]) p_err[2*i +: 2] <= PE_IDLE;
          end
          if (!C_start) begin
            case (C_op)
              OP_NOP: roundOver <= 1'b1;
              OP_UNLOCK: begin
                if (key_ok_s) begin
                  state_r <= ST_UNLOCKED;
                end else begin
                  err     <= ERR_KEY;
                  cnt_r   <= lock_cnt_s;
                  ready   <= 1'b0;
                  state_r <= ST_LOCKOUT;
                end
              end
              default: begin
                err     <= ERR_OP;
                state_r <= ST_LOCKED;
              end
            endcase
          end
        end
        default: state_r <= ST_UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_bid_ctrl_multi.sv
// Table-driven bench for bid_ctrl_multi (4 players): each vector's expectation is queued
// when its inputs are driven and compared after the following rising edge.
module tb_bid_ctrl_multi;

  logic         clk;
  logic         reset_n;
  logic [63:0]  bid_amt;
  logic [3:0]   bid;
  logic [3:0]   retract;
  logic [31:0]  C_data;
  logic [3:0]   C_op;
  logic [1:0]   C_sel;
  logic         C_start;
  logic [3:0]   ack;
  logic [7:0]   p_err;
  logic [127:0] balance;
  logic [3:0]   win;
  logic         ready;
  logic [2:0]   err;
  logic         roundOver;
  logic [31:0]  maxBid;

  bid_ctrl_multi dut (
    .clk(clk), .reset_n(reset_n), .bid_amt(bid_amt), .bid(bid), .retract(retract),
    .C_data(C_data), .C_op(C_op), .C_sel(C_sel), .C_start(C_start),
    .ack(ack), .p_err(p_err), .balance(balance), .win(win), .ready(ready),
    .err(err), .roundOver(roundOver), .maxBid(maxBid)
  );

  typedef struct {
    logic [3:0]   op;
    logic [31:0]  data;
    logic [1:0]   sel;
    logic         start;
    logic [3:0]   bid;
    logic [3:0]   ret;
    logic [63:0]  amt;
    logic [3:0]   ack;
    logic [7:0]   perr;
    logic [2:0]   err;
    logic [3:0]   win;
    logic [31:0]  maxbid;
    logic         ready;
    logic         rover;
    logic [127:0] bal;
  } vec_t;

  vec_t tbl[$];
  vec_t tail[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] amts(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [127:0] bals(input int b0, input int b1, input int b2, input int b3);
    return {32'(b3), 32'(b2), 32'(b1), 32'(b0)};
  endfunction

  function automatic vec_t v(input logic [3:0] op, input logic [31:0] data, input logic [1:0] sel,
                             input logic start, input logic [3:0] b, input logic [3:0] r,
                             input logic [63:0] amt, input logic [3:0] eack, input logic [7:0] eperr,
                             input logic [2:0] eerr, input logic [3:0] ewin, input logic [31:0] emax,
                             input logic erdy, input logic erov, input logic [127:0] ebal);
    vec_t x;
    x.op = op; x.data = data; x.sel = sel; x.start = start; x.bid = b; x.ret = r; x.amt = amt;
    x.ack = eack; x.perr = eperr; x.err = eerr; x.win = ewin; x.maxbid = emax;
    x.ready = erdy; x.rover = erov; x.bal = ebal;
    return x;
  endfunction

  task automatic check(input string name, input vec_t e);
    n_vec++;
    if (ack !== e.ack || p_err !== e.perr || err !== e.err || win !== e.win ||
        maxBid !== e.maxbid || ready !== e.ready || roundOver !== e.rover || balance !== e.bal) begin
      n_bad++;
      $display("FAIL %s got/exp: ack=%b/%b p_err=%b/%b err=%b/%b win=%b/%b maxBid=%0d/%0d ready=%b/%b roundOver=%b/%b balance=%h/%h",
               name, ack, e.ack, p_err, e.perr, err, e.err, win, e.win, maxBid, e.maxbid,
               ready, e.ready, roundOver, e.rover, balance, e.bal);
    end
  endtask

  task automatic apply(input string name, input vec_t x);
    vec_t e;
    C_op = x.op; C_data = x.data; C_sel = x.sel; C_start = x.start;
    bid = x.bid; retract = x.ret; bid_amt = x.amt;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s scoreboard empty: got 0 entries, need 1", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] b0, b1, b2, b3, b4, b5, b6;
    vec_t zero;
    b0 = bals(0, 0, 0, 0);     b1 = bals(0, 100, 0, 0);   b2 = bals(50, 100, 0, 0);
    b3 = bals(50, 100, 60, 0); b4 = bals(29, 100, 60, 0); b5 = bals(100, 100, 60, 0);
    b6 = bals(69, 100, 59, 0);
    zero = v(4'd0, 32'd0, 2'd0, 1'b0, 4'b0, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b0, 1'b0, b0);

    // op data sel start bid ret amt | ack perr err win maxBid ready roundOver balance
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b0));
    tbl.push_back(v(4'd3, 32'd100, 2'd1, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b1));
    tbl.push_back(v(4'd3, 32'd50,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b2));
    tbl.push_back(v(4'd3, 32'd60,  2'd2, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd1, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd2, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd9, 32'd0,   2'd0, 1'b1, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd3, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd9, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd4, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b1000, 4'b0, 64'd0, 4'b0, 8'b01000000, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd5, 32'd5,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd2, 32'hA5,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd4, 32'hF,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd4, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0001, 4'b0, 64'd0, 4'b0, 8'b01, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    // first round: P0 funds 50, charge 1
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0001, 4'b0, amts(20, 0, 0, 0), 4'b0001, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0001, 4'b0, amts(40, 0, 0, 0), 4'b0, 8'b10, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b3));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd20, 1'b1, 1'b1, b4));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd20, 1'b1, 1'b1, b4));
    tbl.push_back(v(4'd1, 32'hA5,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd20, 1'b1, 1'b0, b4));
    tbl.push_back(v(4'd3, 32'd100, 2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd20, 1'b1, 1'b0, b5));
    tbl.push_back(v(4'd2, 32'hA5,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd20, 1'b1, 1'b0, b5));
    // tie round: P0 and P2 bid 30 each
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b5));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0101, 4'b0, amts(30, 0, 30, 0), 4'b0101, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b5));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b1, 1'b1, b6));
    tbl.push_back(v(4'd7, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd4, 4'b0001, 32'd30, 1'b1, 1'b0, b6));
    // bad key with timer 5: five cycles with ready low, inputs ignored
    tbl.push_back(v(4'd1, 32'h11,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd1, 4'b0001, 32'd30, 1'b0, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0001, 4'b0, amts(5, 0, 0, 0), 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b0, 1'b0, b6));
    tbl.push_back(v(4'd1, 32'hA5,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b0, 1'b0, b6));
    tbl.push_back(v(4'd9, 32'd0,   2'd0, 1'b1, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b0, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b0, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd5, 32'd3,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd4, 4'b0001, 32'd30, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd1, 32'hA5,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b1, 1'b0, b6));
    // mask 1011 round with retracts and exact-funds boundaries
    tbl.push_back(v(4'd4, 32'hB,   2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd2, 32'hA5,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0001, 32'd30, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0100, 4'b0, amts(0, 0, 5, 0), 4'b0, 8'b00110000, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0001, 4'b0001, amts(3, 0, 0, 0), 4'b0, 8'b00000011, 3'd4, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0010, 4'b0, amts(0, 10, 0, 0), 4'b0010, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0000, 4'b0010, amts(0, 4, 0, 0), 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0000, 4'b0010, amts(0, 7, 0, 0), 4'b0, 8'b00001000, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b1000, 4'b0, amts(0, 0, 0, 0), 4'b0, 8'b10000000, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    tbl.push_back(v(4'd0, 32'd0,   2'd0, 1'b1, 4'b0010, 4'b0, amts(0, 91, 0, 0), 4'b0010, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b6));
    // after the mid-round reset: back in UNLOCKED with cleared balances
    tail.push_back(v(4'd0, 32'd0,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b0));
    tail.push_back(v(4'd1, 32'h0,  2'd0, 1'b0, 4'b0000, 4'b0, 64'd0, 4'b0, 8'b0, 3'd2, 4'b0, 32'd0, 1'b1, 1'b0, b0));
    tail.push_back(v(4'd0, 32'd0,  2'd0, 1'b0, 4'b0001, 4'b0, 64'd0, 4'b0, 8'b01, 3'd0, 4'b0, 32'd0, 1'b1, 1'b0, b0));

    reset_n = 1'b0;
    C_op = 4'd0; C_data = 32'd0; C_sel = 2'd0; C_start = 1'b0;
    bid = 4'b0; retract = 4'b0; bid_amt = 64'd0;
    @(posedge clk);
    #1;
    check("reset", zero);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset asserted mid-round must clear outputs without waiting for a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", zero);
    @(posedge clk);
    #1;
    check("reset_hold", zero);
    reset_n = 1'b1;

    for (int i = 0; i < tail.size(); i++) begin
      apply($sformatf("tail%0d", i), tail[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
